// File: rtl/mem_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_scheduler
// Brief   : Sequences the shared SNN memory port: filter/ifmap streaming into
//           NoC packets, arbitrated ofmap write-back, timestep control.
// Revision: 1.0 - initial release
// ============================================================================
module mem_access_scheduler #(
    parameter int TIMESTEPS  = 2,
    parameter int FILTER_DIM = 5,
    parameter int IFMAP_DIM  = 25,
    parameter int OFMAP_DIM  = 21,
    parameter int DONE_COUNT = 7,
    parameter int ADDR_W     = 12
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [7:0]                       mem_wdata,
    input  logic                             mem_gnt,
    input  logic [7:0]                       mem_rdata,
    input  logic                             mem_rvalid,
    output logic                             noc_valid,
    input  logic                             noc_ready,
    output logic [63:0]                      noc_data,
    input  logic                             wb_valid,
    output logic                             wb_ready,
    input  logic [63:0]                      wb_packet,
    output logic [$clog2(TIMESTEPS+1)-1:0]   timestep,
    output logic                             busy,
    output logic                             done
);

    localparam int c_TS_W    = $clog2(TIMESTEPS + 1);
    localparam int c_CNT_W   = $clog2(IFMAP_DIM);
    localparam int c_PAY_W   = (8 * FILTER_DIM > IFMAP_DIM) ? 8 * FILTER_DIM : IFMAP_DIM;
    localparam int c_IF_BASE = 32;
    localparam int c_OF_BASE = 2048;

    localparam logic [1:0] c_TYPE_IF  = 2'b00;
    localparam logic [1:0] c_TYPE_FLT = 2'b01;
    localparam logic [1:0] c_TYPE_OUT = 2'b11;

    localparam logic [1:0] c_WB_DROP  = 2'd0;
    localparam logic [1:0] c_WB_WRITE = 2'd1;
    localparam logic [1:0] c_WB_DONE  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FLT_RD    = 3'd1,
        ST_FLT_SEND  = 3'd2,
        ST_IF_RD     = 3'd3,
        ST_IF_SEND   = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_FINISH    = 3'd6
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_row;
    logic [c_CNT_W-1:0]   r_issueCol;
    logic [c_CNT_W-1:0]   r_recvCol;
    logic [2:0]           r_pe;
    logic [c_PAY_W-1:0]   r_payload;
    logic                 r_rdPending;
    logic [7:0]           r_doneCnt;

    logic                 r_wbFull;
    logic [1:0]           r_wbKind;
    logic [4:0]           r_wbRow;
    logic [4:0]           r_wbCol;

    logic                 w_isFlt;
    logic                 w_inRead;
    logic [c_CNT_W-1:0]   w_lastCol;
    logic                 w_seqRd;
    logic                 w_portFree;
    logic                 w_wbWrite;
    logic                 w_doneInc;
    logic                 w_startNow;
    logic                 w_rdDone;
    logic                 w_lastRecv;
    logic                 w_doneReached;
    logic [ADDR_W-1:0]    w_rdAddr;
    logic [ADDR_W-1:0]    w_wrAddr;
    logic [c_PAY_W-1:0]   w_payloadNext;
    logic [3:0]           w_dest;
    logic [1:0]           w_wbKindIn;
    logic [2:0]           w_peNext;
    logic                 w_unusedWb;

    assign mem_wdata  = 8'h01;
    assign wb_ready   = !r_wbFull;
    assign w_unusedWb = ^{wb_packet[63:56], wb_packet[53:10]};

    assign w_isFlt       = (r_state == ST_FLT_RD);
    assign w_inRead      = (r_state == ST_FLT_RD) || (r_state == ST_IF_RD);
    assign w_lastCol     = w_isFlt ? c_CNT_W'(FILTER_DIM - 1) : c_CNT_W'(IFMAP_DIM - 1);
    assign w_seqRd       = w_inRead && (r_issueCol <= w_lastCol);
    // The port frees up in the rvalid cycle so the next request lands one cycle later.
    assign w_portFree    = !mem_req && (!r_rdPending || mem_rvalid);
    assign w_wbWrite     = r_wbFull && (r_wbKind == c_WB_WRITE);
    assign w_doneInc     = r_wbFull && (r_wbKind == c_WB_DONE);
    assign w_startNow    = start && ((r_state == ST_IDLE) || (r_state == ST_FINISH));
    assign w_rdDone      = r_rdPending && mem_rvalid;
    assign w_lastRecv    = (r_recvCol == w_lastCol);
    assign w_doneReached = (r_doneCnt >= 8'(DONE_COUNT));
    assign w_peNext      = (r_pe == 3'd4) ? 3'd0 : r_pe + 3'd1;

    always_comb begin
        w_rdAddr = '0;
        if (w_isFlt) begin
            w_rdAddr = ADDR_W'(r_row) * ADDR_W'(FILTER_DIM) + ADDR_W'(r_issueCol);
        end else begin
            w_rdAddr = ADDR_W'(c_IF_BASE)
                     + ADDR_W'(timestep) * ADDR_W'(IFMAP_DIM * IFMAP_DIM)
                     + ADDR_W'(r_row) * ADDR_W'(IFMAP_DIM)
                     + ADDR_W'(r_issueCol);
        end
    end

    assign w_wrAddr = ADDR_W'(c_OF_BASE)
                    + ADDR_W'(timestep) * ADDR_W'(OFMAP_DIM * OFMAP_DIM)
                    + ADDR_W'(r_wbRow) * ADDR_W'(OFMAP_DIM)
                    + ADDR_W'(r_wbCol);

    // Merge the arriving read beat into the row payload (byte per weight, bit per spike).
    always_comb begin
        w_payloadNext = r_payload;
        if (w_isFlt) begin
            for (int i = 0; i < FILTER_DIM; i++) begin
                if (r_recvCol == c_CNT_W'(i)) begin
                    w_payloadNext[8*i +: 8] = mem_rdata;
                end
            end
        end else begin
            for (int i = 0; i < IFMAP_DIM; i++) begin
                if (r_recvCol == c_CNT_W'(i)) begin
                    w_payloadNext[i] = mem_rdata[0];
                end
            end
        end
    end

    always_comb begin
        w_dest = 4'b0001;
        case (r_pe)
            3'd0:    w_dest = 4'b0001;
            3'd1:    w_dest = 4'b0101;
            3'd2:    w_dest = 4'b0011;
            3'd3:    w_dest = 4'b0111;
            default: w_dest = 4'b1100;
        endcase
    end

    always_comb begin
        w_wbKindIn = c_WB_DROP;
        if (wb_packet[55:54] == c_TYPE_OUT) begin
            if (wb_packet[9:0] == 10'h1FF) begin
                w_wbKindIn = c_WB_DONE;
            end else if ((wb_packet[9:5] < 5'(OFMAP_DIM)) && (wb_packet[4:0] < 5'(OFMAP_DIM))) begin
                w_wbKindIn = c_WB_WRITE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_row       <= '0;
            r_issueCol  <= '0;
            r_recvCol   <= '0;
            r_pe        <= '0;
            r_payload   <= '0;
            r_rdPending <= 1'b0;
            r_doneCnt   <= '0;
            r_wbFull    <= 1'b0;
            r_wbKind    <= c_WB_DROP;
            r_wbRow     <= '0;
            r_wbCol     <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            noc_valid   <= 1'b0;
            noc_data    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timestep    <= '0;
        end else begin
            // Write-back buffer: non-write entries are retired the cycle after capture.
            if (!r_wbFull) begin
                if (wb_valid) begin
                    r_wbFull <= 1'b1;
                    r_wbKind <= w_wbKindIn;
                    r_wbRow  <= wb_packet[9:5];
                    r_wbCol  <= wb_packet[4:0];
                end
            end else if (!w_wbWrite) begin
                r_wbFull <= 1'b0;
            end else if (mem_req && mem_we && mem_gnt) begin
                r_wbFull <= 1'b0;
            end

            if ((r_state == ST_WAIT_DONE) && w_doneReached) begin
                r_doneCnt <= w_doneInc ? 8'd1 : 8'd0;
            end else if (w_doneInc && (r_doneCnt != 8'hFF)) begin
                r_doneCnt <= r_doneCnt + 8'd1;
            end

            if (mem_req && mem_gnt) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                if (!mem_we) begin
                    r_rdPending <= 1'b1;
                end
            end
            if (w_rdDone) begin
                r_rdPending <= 1'b0;
            end

            case (r_state)
                ST_IDLE, ST_FINISH: begin
                    if (start) begin
                        r_state    <= ST_FLT_RD;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        timestep   <= '0;
                        r_row      <= '0;
                        r_issueCol <= '0;
                        r_recvCol  <= '0;
                        r_pe       <= '0;
                        r_payload  <= '0;
                    end
                end
                ST_FLT_RD, ST_IF_RD: begin
                    if (w_rdDone) begin
                        r_payload <= w_payloadNext;
                        r_recvCol <= r_recvCol + c_CNT_W'(1);
                        if (w_lastRecv) begin
                            noc_valid <= 1'b1;
                            noc_data  <= {w_dest, 4'b0000, (w_isFlt ? c_TYPE_FLT : c_TYPE_IF),
                                          54'(w_payloadNext)};
                            r_payload <= '0;
                            r_state   <= w_isFlt ? ST_FLT_SEND : ST_IF_SEND;
                        end
                    end
                end
                ST_FLT_SEND: begin
                    if (noc_ready) begin
                        noc_valid  <= 1'b0;
                        r_issueCol <= '0;
                        r_recvCol  <= '0;
                        if (r_row == c_CNT_W'(FILTER_DIM - 1)) begin
                            r_state <= ST_IF_RD;
                            r_row   <= '0;
                            r_pe    <= '0;
                        end else begin
                            r_state <= ST_FLT_RD;
                            r_row   <= r_row + c_CNT_W'(1);
                            r_pe    <= w_peNext;
                        end
                    end
                end
                ST_IF_SEND: begin
                    if (noc_ready) begin
                        noc_valid  <= 1'b0;
                        r_issueCol <= '0;
                        r_recvCol  <= '0;
                        if (r_row == c_CNT_W'(IFMAP_DIM - 1)) begin
                            r_state <= ST_WAIT_DONE;
                            r_row   <= '0;
                            r_pe    <= '0;
                        end else begin
                            r_state <= ST_IF_RD;
                            r_row   <= r_row + c_CNT_W'(1);
                            r_pe    <= w_peNext;
                        end
                    end
                end
                ST_WAIT_DONE: begin
                    if (w_doneReached) begin
                        timestep <= timestep + c_TS_W'(1);
                        if ((timestep + c_TS_W'(1)) == c_TS_W'(TIMESTEPS)) begin
                            r_state <= ST_FINISH;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state    <= ST_IF_RD;
                            r_row      <= '0;
                            r_issueCol <= '0;
                            r_recvCol  <= '0;
                            r_pe       <= '0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Port arbitration: a buffered write wins over any sequencer read.
            if (w_portFree) begin
                if (w_wbWrite) begin
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b1;
                    mem_addr <= w_wrAddr;
                end else if (w_startNow) begin
                    mem_req    <= 1'b1;
                    mem_we     <= 1'b0;
                    mem_addr   <= '0;
                    r_issueCol <= c_CNT_W'(1);
                end else if (w_seqRd) begin
                    mem_req    <= 1'b1;
                    mem_we     <= 1'b0;
                    mem_addr   <= w_rdAddr;
                    r_issueCol <= r_issueCol + c_CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_access_scheduler.md
# mem_access_scheduler

Synthesizable clocked controller that sequences the single shared activation/weight memory port for the SNN accelerator. It streams the 5x5 filter once, then the 25x25 input spike map per timestep, packing rows into 64-bit NoC packets. It also arbitrates ofmap spike write-backs arriving from the NoC onto the same port, and advances the timestep on DONE-packet count.

## Interface
- TIMESTEPS, 2, number of timesteps to run
- FILTER_DIM, 5, filter rows/cols (8-bit weights)
- IFMAP_DIM, 25, ifmap rows/cols (1-bit spikes)
- OFMAP_DIM, 21, ofmap rows/cols
- DONE_COUNT, 7, DONE packets that close a timestep
- ADDR_W, 12, memory address width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse begins a run; ignored while busy
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  8  write data (always 8'h01)
- mem_gnt  in  1  request accepted this cycle
- mem_rdata  in  8  read data (bit 0 for spikes)
- mem_rvalid  in  1  read data valid, one pulse per granted read
- noc_valid / noc_ready  out / in  1  outgoing packet handshake
- noc_data  out  64  outgoing packet
- wb_valid / wb_ready  in / out  1  incoming NoC packet handshake
- wb_packet  in  64  incoming packet
- timestep  out  $clog2(TIMESTEPS+1)  current timestep
- busy  out  1  run in progress
- done  out  1  all timesteps complete; held until next start

## Operation
- Address map: filter = row*FILTER_DIM+col; ifmap = 32 + t*IFMAP_DIM² + row*IFMAP_DIM+col; ofmap = 2048 + t*OFMAP_DIM² + row*OFMAP_DIM+col.
- Packet: [63:60] dest, [59:56] src = 4'b0000, [55:54] type (00 ifmap, 01 filter, 11 output), rest payload, upper payload bits zero.
- Dest for row r = PE table[r mod 5]: 0001, 0101, 0011, 0111, 1100.
- Filter payload [39:0] = {col4,…,col0} bytes. Ifmap payload: bit j = spike at col j, [24:0].
- FSM: IDLE -start-> FLT_RD (5 reads of one row) -> FLT_SEND (one packet) -> FLT_RD next row, or after row 4 -> IF_RD (25 reads) -> IF_SEND -> IF_RD next row, or after row 24 -> WAIT_DONE.
- WAIT_DONE: when done_cnt ≥ DONE_COUNT, clear done_cnt and increment timestep. If timestep reaches TIMESTEPS -> FINISH, else -> IF_RD row 0.
- FINISH: done=1, busy=0; start -> FLT_RD with timestep=0, done=0.
- Write-back:
  - One-entry buffer; wb_ready = buffer empty.
  - Only type 11 packets are kept; others are consumed and dropped.
  - If [9:0] == 10'h1FF: done_cnt++, no write.
  - Else if row [9:5] < OFMAP_DIM and col [4:0] < OFMAP_DIM: write using the current timestep. Otherwise dropped.
  - DONE packets are counted in any state, including before WAIT_DONE.
- Arbitration: one outstanding access. When the port is free, a pending write beats a sequencer read.

## Timing
- Reset values: mem_req, mem_we, mem_addr, noc_valid, noc_data, busy, done, timestep, done_cnt = 0; wb_ready = 1; mem_wdata = 8'h01; FSM = IDLE; buffer empty.
- busy rises the cycle after the start pulse; the first mem_req is asserted in that same cycle.
- mem_req, mem_we, mem_addr, mem_wdata are held stable until the cycle in which mem_gnt=1.
- Read: earliest mem_rvalid is one cycle after the grant. The next request is issued at the earliest the cycle after mem_rvalid.
- Write: complete at the grant; the port is free the next cycle.
- Packet send: noc_valid is raised the cycle after the last row read's mem_rvalid. noc_data is held until noc_ready; no reads are issued while a packet is pending.
- wb_ready deasserts the cycle after wb_valid&&wb_ready. It reasserts the cycle after the write is granted, or after the packet is consumed if it is dropped or DONE.
- Reset mid-operation clears all state asynchronously; a buffered write-back is lost.

## Test plan
- Filter load: memory filter[r][c] = r*5+c+1. Pulse start -> 25 reads at addr 0..24, then 5 packets; first = 64'h1040_0005_0403_0201, last dest 1100.
- Ifmap: t=0 row 0 all ones, row 5 all zeros -> packet 64'h1000_0000_01FF_FFFF. Row 5 packet = 64'h1000_0000_0000_0000 with dest 0001.
- Write-back: wb_packet 64'h00C0_0000_0000_0067 at t=0 -> one write, addr 2118, wdata 8'h01. Row 21 -> no write. Type 00 -> dropped.
- Timestep advance: 7 packets 64'h00C0_0000_0000_01FF in WAIT_DONE -> timestep=1, next read addr 657. After t=1 closes -> done=1, busy=0.
- Contention and backpressure:
  - wb_valid while an ifmap read is outstanding -> the write is issued right after mem_rvalid, before the next read.
  - noc_ready=0 for 10 cycles -> noc_data stable and no mem_req.
- Reset mid-FLT_RD (rst_n low 1 cycle) -> all outputs at reset values. A new start restarts at addr 0.
